// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard read path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int PS2_FRAME_BITS = 11;

    // Scan-code prefixes consumed by downstream key logic.
    localparam logic [7:0] BREAK  = 8'hF0;
    localparam logic [7:0] EXTEND = 8'hE0;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_glitch_filter.sv
// Debounces one raw PS/2 line: the output only moves after FILTER_LEN
// consecutive equal samples, including the sample taken this cycle.
module ps2_glitch_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_25,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [FILTER_LEN-2:0] hist_q;
    logic [FILTER_LEN-1:0] window;
    logic                  dout_q;
    logic                  dout_d;

    assign window = {hist_q, din};

    // NOTE: default assignment first, so every path assigns dout_d and no latch is inferred.
    always_comb begin
        dout_d = dout_q;
        if (&window) begin
            dout_d = 1'b1;
        end else if (~|window) begin
            dout_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments here so all flops update together on the edge.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '1;
            dout_q <= 1'b1;
        end else begin
            hist_q <= window[FILTER_LEN-2:0];
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: filtered lines, frame FSM with timeout, and a small
// first-word-fall-through byte FIFO plus the last two good bytes.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic                          clk_25,
    input  logic                          rst_n,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    code,
    output logic [7:0]                    code_prev,
    output logic                          rx_strobe,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic ps2c_f, ps2d_f, ps2c_prev_q, fall;

    ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk_25(clk_25), .rst_n(rst_n), .din(ps2c), .dout(ps2c_f)
    );
    ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk_25(clk_25), .rst_n(rst_n), .din(ps2d), .dout(ps2d_f)
    );

    assign fall = ps2c_prev_q & ~ps2c_f;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          good, perr, ferr;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        to_cnt_d  = to_cnt_q;
        good      = 1'b0;
        perr      = 1'b0;
        ferr      = 1'b0;

        // A stalled frame is abandoned; a falling edge always restarts the count.
        if (state_q == IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d  = IDLE;
            ferr     = 1'b1;
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!ps2d_f) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {ps2d_f, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = ps2d_f;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!ps2d_f)                            ferr = 1'b1;
                    else if (odd_parity_ok(shift_q, parity_q)) good = 1'b1;
                    else                                    perr = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, push, pop, drop;
    logic [7:0]    code_q, code_prev_q;
    logic          rx_strobe_q, parity_err_q, frame_err_q, overflow_q;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = rd_en & ~empty;
    assign push  = good & (~full | pop);
    assign drop  = good & full & ~pop;

    // NOTE: the storage array has no reset; only pointers and count need a known state.
    always_ff @(posedge clk_25) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            ps2c_prev_q  <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            code_q       <= '0;
            code_prev_q  <= '0;
            rx_strobe_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            ps2c_prev_q  <= ps2c_f;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            rx_strobe_q  <= good;
            parity_err_q <= perr;
            frame_err_q  <= ferr;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
            if (good) begin
                code_prev_q <= code_q;
                code_q      <= shift_q;
            end
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign rd_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign rd_valid   = ~empty;
    assign fifo_count = count_q;
    assign code       = code_q;
    assign code_prev  = code_prev_q;
    assign rx_strobe  = rx_strobe_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: PS/2 frames driven on the pins, expected
// FIFO bytes queued at send time and compared on each pop.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int FD   = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clk_25 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ps2c   = 1'b1;
    logic       ps2d   = 1'b1;
    logic       rd_en  = 1'b0;
    logic [7:0] rd_data, code, code_prev;
    logic       rd_valid, rx_strobe, parity_err, frame_err, overflow;
    logic [2:0] fifo_count;

    always #20 clk_25 = ~clk_25;

    ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)) dut (
        .clk_25(clk_25), .rst_n(rst_n), .ps2c(ps2c), .ps2d(ps2d), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .code(code), .code_prev(code_prev), .rx_strobe(rx_strobe),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    int         n_cmp = 0, n_bad = 0;
    int         n_strobe = 0, n_perr = 0, n_ferr = 0;
    int         exp_strobe = 0, exp_perr = 0, exp_ferr = 0;
    logic [7:0] exp_code = 8'h00, exp_prev = 8'h00;
    logic       exp_ovf = 1'b0;
    logic [7:0] sb_q[$];

    // Pulse outputs are counted in cycles-high, so a stuck pulse shows up as extra counts.
    always @(negedge clk_25) begin
        if (rst_n) begin
            n_strobe += int'(rx_strobe);
            n_perr   += int'(parity_err);
            n_ferr   += int'(frame_err);
        end
    end

    initial begin
        #(60000 * 40);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_half();
        repeat (HALF) @(negedge clk_25);
    endtask

    task automatic ps2_bit(input logic b);
        ps2d = b;
        wait_half();
        ps2c = 1'b0;
        wait_half();
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input bit pop_at_commit);
        logic par;
        par = ~(^b) ^ flip_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2d = 1'b1;
        wait_half();
        ps2c = 1'b0;
        if (pop_at_commit) begin
            // The stop edge commits FL clocks after the pin falls; pop on that same clock.
            repeat (FL) @(posedge clk_25);
            @(negedge clk_25);
            check("commit.head", rd_data, sb_q[0]);
            rd_en = 1'b1;
            @(posedge clk_25);
            #1;
            check("commit.strobe", rx_strobe, 1);
            check("commit.count", fifo_count, FD);
            @(negedge clk_25);
            rd_en = 1'b0;
            void'(sb_q.pop_front());
            repeat (HALF - FL - 2) @(negedge clk_25);
        end else begin
            wait_half();
        end
        ps2c = 1'b1;
        repeat (3 * HALF) @(negedge clk_25);
    endtask

    task automatic expect_good(input logic [7:0] b);
        exp_strobe++;
        exp_prev = exp_code;
        exp_code = b;
        if (sb_q.size() < FD) sb_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic check_status(input string tag);
        @(negedge clk_25);
        check({tag, ".code"}, code, exp_code);
        check({tag, ".code_prev"}, code_prev, exp_prev);
        check({tag, ".count"}, fifo_count, sb_q.size());
        check({tag, ".valid"}, rd_valid, sb_q.size() != 0);
        check({tag, ".overflow"}, overflow, exp_ovf);
        check({tag, ".strobes"}, n_strobe, exp_strobe);
        check({tag, ".perr"}, n_perr, exp_perr);
        check({tag, ".ferr"}, n_ferr, exp_ferr);
    endtask

    task automatic pop_one();
        logic [7:0] exp_b;
        @(negedge clk_25);
        exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
        check("pop.valid", rd_valid, 1);
        check("pop.data", rd_data, exp_b);
        rd_en = 1'b1;
        @(negedge clk_25);
        rd_en = 1'b0;
        check("pop.count", fifo_count, sb_q.size());
    endtask

    initial begin
        logic [7:0] burst [5];
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44; burst[4] = 8'h55;

        repeat (4) @(negedge clk_25);
        check_status("reset");
        check("reset.rd_data", rd_data, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_25);

        send_frame(8'h1C, 1'b0, 0);
        expect_good(8'h1C);
        check_status("single");
        check("single.rd_data", rd_data, 8'h1C);
        pop_one();

        send_frame(BREAK, 1'b0, 0);
        expect_good(BREAK);
        send_frame(8'h1C, 1'b0, 0);
        expect_good(8'h1C);
        check_status("pair");
        pop_one();
        pop_one();
        check("pair.drained", rd_valid, 0);

        send_frame(8'h29, 1'b1, 0);
        exp_perr++;
        check_status("badpar");
        send_frame(8'h29, 1'b0, 0);
        expect_good(8'h29);
        check_status("goodpar");
        pop_one();

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 50) @(negedge clk_25);
        exp_ferr++;
        check_status("timeout");
        send_frame(8'h5A, 1'b0, 0);
        expect_good(8'h5A);
        check_status("after_to");
        pop_one();

        foreach (burst[i]) begin
            send_frame(burst[i], 1'b0, 0);
            expect_good(burst[i]);
        end
        check_status("full");
        send_frame(8'h66, 1'b0, 1);
        exp_strobe++;
        exp_prev = exp_code;
        exp_code = 8'h66;
        sb_q.push_back(8'h66);
        check_status("push_pop_full");
        while (sb_q.size() > 0) pop_one();

        for (int g = 0; g < 4; g++) begin
            ps2c = 1'b0;
            repeat (3) @(negedge clk_25);
            ps2c = 1'b1;
            repeat (10) @(negedge clk_25);
        end
        check_status("glitch");

        send_frame(8'h77, 1'b0, 0);
        expect_good(8'h77);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2d = 1'b0;
        ps2c = 1'b0;
        repeat (HALF) @(negedge clk_25);
        rst_n = 1'b0;
        #1;
        check("rst.valid", rd_valid, 0);
        check("rst.count", fifo_count, 0);
        check("rst.rd_data", rd_data, 8'h00);
        check("rst.code", code, 8'h00);
        check("rst.code_prev", code_prev, 8'h00);
        check("rst.overflow", overflow, 0);
        check("rst.pulses", {rx_strobe, parity_err, frame_err}, 3'b000);
        ps2c = 1'b1;
        ps2d = 1'b1;
        sb_q.delete();
        exp_code = 8'h00;
        exp_prev = 8'h00;
        exp_ovf  = 1'b0;
        repeat (4) @(negedge clk_25);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_25);
        check_status("post_rst");
        send_frame(8'h3C, 1'b0, 0);
        expect_good(8'h3C);
        check_status("recover");
        pop_one();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 keyboard receiver; next generation of the team's PS/2 read path.
- Filters PS/2 clock and data, frames the 11-bit packet in the system clock domain, checks start/parity/stop bits and recovers from stalled frames by timeout.
- Buffers good bytes in a small FIFO and keeps the last two good bytes visible for the game's key logic.

Parameters:
- FILTER_LEN, 8, number of consecutive equal samples needed to change a filtered line (>=2).
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >=2.
- TIMEOUT_CYC, 25000, idle clk_25 cycles inside a frame before abort (1 ms at 25 MHz).

Ports:
- clk_25  in  1  system clock, 25 MHz
- rst_n  in  1  asynchronous active-low reset
- ps2c  in  1  raw PS/2 clock from pin
- ps2d  in  1  raw PS/2 data from pin
- rd_en  in  1  pop one FIFO entry this cycle
- rd_data  out  8  FIFO head byte; valid while rd_valid=1
- rd_valid  out  1  FIFO not empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- code  out  8  most recent good byte
- code_prev  out  8  good byte before code
- rx_strobe  out  1  one-cycle pulse when a good byte is accepted
- parity_err  out  1  one-cycle pulse: odd-parity failure
- frame_err  out  1  one-cycle pulse: bad stop bit or timeout
- overflow  out  1  sticky; set when a good byte arrives with FIFO full; cleared only by reset

Behaviour:
- Reset (async, rst_n=0) sets:
  - both filtered lines and their filter shift registers to 1;
  - FSM to IDLE, FIFO pointers to 0, bit counter and timeout counter to 0;
  - all outputs to 0.
- Filter: each line shifts in one sample per clk_25. The filtered line goes to 1 after FILTER_LEN consecutive 1s and to 0 after FILTER_LEN consecutive 0s; otherwise it holds.
- Falling edge of the filtered clock is detected synchronously (previous=1, current=0). No logic is clocked by ps2c.
- FSM states: IDLE, DATA, PARITY, STOP. Each transition happens on a falling edge.
  - IDLE: if data=0 (start bit), go to DATA and clear the bit counter; if data=1, stay in IDLE.
  - DATA: shift data in LSB-first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: go to IDLE in all cases. Stop=1 with odd parity over 8 data bits plus parity bit gives a good byte. Stop=1 with bad parity pulses parity_err only. Stop=0 pulses frame_err only (it takes precedence over parity).
- Timeout: counter clears on every falling edge and whenever the FSM is in IDLE. If it reaches TIMEOUT_CYC-1 while not in IDLE, the FSM returns to IDLE and frame_err pulses. Partial data is discarded.
- Good byte, in the cycle after the STOP edge:
  - rx_strobe=1, code_prev<=code, code<=byte;
  - push the byte to the FIFO unless it is full. If full, drop the byte, set overflow, and still update code/code_prev.
- FIFO is first-word-fall-through: rd_data shows the head combinationally from the registered array.
  - rd_en with the FIFO empty is ignored.
  - Push and pop in the same cycle: allowed at any occupancy, including full; fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: the stop-bit falling edge on the filtered clock produces rx_strobe and the new rd_valid/fifo_count one clk_25 later.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - constant PS2_FRAME_BITS=11;
  - the scan-code constants BREAK=8'hF0 and EXTEND=8'hE0, for downstream key logic.
- Sub-module ps2_glitch_filter (parameter FILTER_LEN, ports clk_25, rst_n, din, dout) is instantiated twice, once for ps2c and once for ps2d.
- The FIFO stays inline.

Test Plan:
- Reset, then frame for 8'h1C (start 0, data LSB-first, parity 0, stop 1) at 10 kHz PS/2 clock -> one rx_strobe; code=8'h1C, rd_data=8'h1C, fifo_count=1, no errors.
- Frames 8'hF0 then 8'h1C -> code=8'h1C, code_prev=8'hF0; rd_en pops 8'hF0 then 8'h1C; fifo_count goes 2,1,0 and rd_valid drops.
- Frame 8'h29 with parity bit flipped -> parity_err pulse; no rx_strobe; FIFO and code unchanged. The next good frame 8'h29 is accepted normally.
- Start bit plus 4 data bits, then the clock stops for more than TIMEOUT_CYC cycles -> frame_err pulse and FSM in IDLE. A following full frame 8'h5A is received correctly.
- FIFO_DEPTH=4: send 5 good bytes without reading -> fifo_count=4 and overflow=1. The 5th byte is dropped from the FIFO but appears on code. Assert rd_en on the cycle a 6th byte's rx_strobe fires -> count stays 4.
- 3-cycle glitches on ps2c during IDLE, plus rst_n pulsed low mid-frame -> no edges seen, no false bytes; all outputs return to 0 immediately on reset assertion.
